// File: rtl/prog_loader_pkg.sv
// Shared state encoding and instruction constants for the program loader and
// the 4-bit CPU core it feeds.
package prog_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_e;

    // ADD A,0: harmless filler for unwritten or cleared program words
    localparam logic [7:0] NOP_WORD = 8'h00;

    localparam logic [3:0] OP_ADD_A = 4'h0;
    localparam logic [3:0] OP_MOV_A = 4'h3;
    localparam logic [3:0] OP_MOV_B = 4'h7;
    localparam logic [3:0] OP_OUT_B = 4'h9;
    localparam logic [3:0] OP_OUT_I = 4'hB;
    localparam logic [3:0] OP_JMP   = 4'hF;

    function automatic logic [7:0] mk_instr(input logic [3:0] op, input logic [3:0] imm);
        return {op, imm};
    endfunction

endpackage

// File: rtl/prog_loader_rom_if.sv
// CPU fetch port plus the valid/ready program byte stream into the loader.
interface prog_loader_rom_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              load_start;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;

    modport master (output addr, load_start, load_valid, load_data,
                    input  data, load_ready);
    modport slave  (input  addr, load_start, load_valid, load_data,
                    output data, load_ready);
endinterface

// File: rtl/prog_mem_16x8.sv
// Program store: synchronous write, combinational read, cleared to NOPs on reset.
module prog_mem_16x8
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= DATA_W'(NOP_WORD);
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/prog_loader_rom.sv
// Writable instruction ROM for the 4-bit CPU; keeps the CPU in reset while a
// new program streams in and for HOLD_CYCLES afterwards.
module prog_loader_rom
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    prog_loader_rom_if.slave  bus,
    output logic              cpu_n_reset,
    output logic              busy,
    output logic [DATA_W-1:0] load_sum
);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_e            state, state_nxt;
    logic [7:0]        hold_cnt;
    logic [ADDR_W-1:0] wr_ptr;
    logic              ready, start, accept, last_byte;

    assign ready          = (state == LOAD);
    assign bus.load_ready = ready;
    assign busy           = (state != IDLE);

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        accept    = bus.load_valid & ready;
        last_byte = accept && (wr_ptr == {ADDR_W{1'b1}});
        case (state)
            IDLE: if (bus.load_start) begin
                start     = 1'b1;
                state_nxt = LOAD;
            end
            LOAD: if (last_byte) state_nxt = HOLD;
            HOLD: if (hold_cnt == HOLD_LAST) state_nxt = IDLE;
            default: state_nxt = HOLD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= HOLD;
            hold_cnt    <= '0;
            wr_ptr      <= '0;
            load_sum    <= '0;
            cpu_n_reset <= 1'b0;
        end else begin
            state       <= state_nxt;
            cpu_n_reset <= (state_nxt == IDLE);
            if (start) begin
                wr_ptr   <= '0;
                load_sum <= '0;
            end else if (accept) begin
                wr_ptr   <= wr_ptr + ADDR_W'(1);
                load_sum <= load_sum + bus.load_data;
            end
            // hold count restarts on the final byte so the release delay is fixed
            if (last_byte)          hold_cnt <= '0;
            else if (state == HOLD) hold_cnt <= hold_cnt + 8'd1;
        end
    end

    prog_mem_16x8 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (accept),
        .waddr (wr_ptr),
        .wdata (bus.load_data),
        .raddr (bus.addr),
        .rdata (bus.data)
    );

endmodule

// File: tb/tb_prog_loader_rom.sv
// Bench for prog_loader_rom: scenario tasks against a behavioural program model
// and a tiny behavioural CPU fed from the ROM.
module tb_prog_loader_rom;
    import prog_loader_pkg::*;

    localparam int HOLD_N = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cpu_n_reset, busy;
    logic [7:0] load_sum;
    logic       cpu_mode = 1'b0;
    logic [3:0] rd_addr = 4'd0;
    logic [3:0] cpu_ip, cpu_a, cpu_b, led;
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;

    prog_loader_rom_if #(.ADDR_W(4), .DATA_W(8)) bus ();
    assign bus.addr = cpu_mode ? cpu_ip : rd_addr;

    prog_loader_rom #(.ADDR_W(4), .DATA_W(8), .HOLD_CYCLES(HOLD_N)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .cpu_n_reset (cpu_n_reset),
        .busy        (busy),
        .load_sum    (load_sum)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Minimal CPU: fetch at ip, execute, with cpu_n_reset sampled at the edge
    always @(posedge clk) begin
        if (!cpu_n_reset) begin
            cpu_ip <= 4'd0; cpu_a <= 4'd0; cpu_b <= 4'd0; led <= 4'd0;
        end else begin
            cpu_ip <= cpu_ip + 4'd1;
            case (bus.data[7:4])
                OP_ADD_A: cpu_a  <= cpu_a + bus.data[3:0];
                OP_MOV_A: cpu_a  <= bus.data[3:0];
                OP_MOV_B: cpu_b  <= bus.data[3:0];
                OP_OUT_B: led    <= cpu_b;
                OP_OUT_I: led    <= bus.data[3:0];
                OP_JMP:   cpu_ip <= bus.data[3:0];
                default: ;
            endcase
        end
    end

    // Stimulus only: streams prog, reports what it observed for the tests to judge
    task automatic run_load(input logic [7:0] prog [16], input int vmode, input int stop_after,
                            input int start_at, output int rdy_cnt, output int drv_cnt,
                            output int last_edge, output bit timeout);
        int n; bit v; bit rdy; bit pulsed;
        n = 0; rdy_cnt = 0; drv_cnt = 0; last_edge = -1; timeout = 1'b0; pulsed = 1'b0;
        @(negedge clk);
        bus.load_start = 1'b1;
        @(negedge clk);
        while (n < stop_after && !timeout) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = (drv_cnt % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            bus.load_start = (n == start_at && !pulsed);
            if (bus.load_start) pulsed = 1'b1;
            bus.load_valid = v;
            bus.load_data  = v ? prog[n] : 8'($urandom);
            rdy = bus.load_ready;
            if (rdy) rdy_cnt++;
            drv_cnt++;
            @(negedge clk);
            if (v && rdy) begin
                n++;
                if (n == stop_after) last_edge = cyc;
            end
            if (drv_cnt >= 200) timeout = 1'b1;
        end
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
    endtask

    task automatic wait_idle(output bit timeout);
        int n;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        timeout = (n >= 100);
    endtask

    function automatic logic [7:0] model_sum(input logic [7:0] prog [16]);
        int s;
        s = 0;
        for (int i = 0; i < 16; i++) s += prog[i];
        return 8'(s % 256);
    endfunction

    task automatic test_reset();
        bit rel;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checks++;
        if (cpu_n_reset !== 1'b0) begin errors++; $display("FAIL reset_cpu_n_reset got=%b want=0", cpu_n_reset); end
        checks++;
        if (load_sum !== 8'h00) begin errors++; $display("FAIL reset_load_sum got=%h want=00", load_sum); end
        // value held after edge e is what the CPU samples at edge e+1
        for (int e = 1; e <= HOLD_N + 2; e++) begin
            @(negedge clk);
            rel = (e >= HOLD_N);
            checks++;
            if (cpu_n_reset !== rel) begin errors++; $display("FAIL reset_release edge=%0d got=%b want=%b", e, cpu_n_reset, rel); end
            checks++;
            if (busy !== !rel) begin errors++; $display("FAIL reset_busy edge=%0d got=%b want=%b", e, busy, !rel); end
        end
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a); #1;
            checks++;
            if (bus.data !== NOP_WORD) begin errors++; $display("FAIL reset_mem addr=%0d got=%h want=%h", a, bus.data, NOP_WORD); end
        end
    endtask

    // Shared body for loads that must complete: timing, checksum and contents
    task automatic test_load_case(input string name, input logic [7:0] prog [16], input int vmode,
                                  input int exp_drv);
        int rdy, drv, last; bit to;
        wait_idle(to);
        checks++;
        if (to) begin errors++; $display("FAIL %s_idle_wait busy=%b want=0", name, busy); end
        run_load(prog, vmode, 16, -1, rdy, drv, last, to);
        checks++;
        if (to) begin errors++; $display("FAIL %s_timeout accepted_cycles=%0d want=16 accepts", name, drv); end
        checks++;
        if (rdy !== drv || (exp_drv > 0 && drv !== exp_drv))
            begin errors++; $display("FAIL %s_ready ready_cycles=%0d load_cycles=%0d want=%0d", name, rdy, drv, exp_drv > 0 ? exp_drv : drv); end
        checks++;
        if (load_sum !== model_sum(prog)) begin errors++; $display("FAIL %s_sum got=%h want=%h", name, load_sum, model_sum(prog)); end
        for (int j = 0; j <= HOLD_N; j++) begin
            if (j > 0) @(negedge clk);
            checks++;
            if (cpu_n_reset !== (j == HOLD_N)) begin errors++; $display("FAIL %s_release edge=last+%0d got=%b want=%b", name, j, cpu_n_reset, j == HOLD_N); end
        end
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a); #1;
            checks++;
            if (bus.data !== prog[a]) begin errors++; $display("FAIL %s_mem addr=%0d got=%h want=%h", name, a, bus.data, prog[a]); end
        end
    endtask

    task automatic test_full_load();
        logic [7:0] prog [16];
        prog[0] = 8'h30;
        for (int i = 1; i < 16; i++) prog[i] = 8'(i);
        checks++;
        if (model_sum(prog) !== 8'ha8) begin errors++; $display("FAIL full_model_sum got=%h want=a8", model_sum(prog)); end
        test_load_case("full", prog, 0, 16);
    endtask

    task automatic test_gapped_valid();
        logic [7:0] prog [16];
        prog[0] = 8'h30;
        for (int i = 1; i < 16; i++) prog[i] = 8'(i);
        test_load_case("gapped", prog, 1, 31);
    endtask

    task automatic test_random_loads();
        logic [7:0] prog [16];
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
            test_load_case("random", prog, 2, 0);
        end
    endtask

    task automatic test_ignored_starts();
        logic [7:0] prog [16];
        int rdy, drv, last; bit to;
        for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
        wait_idle(to);
        run_load(prog, 0, 16, 5, rdy, drv, last, to);
        checks++;
        if (to || drv !== 16) begin errors++; $display("FAIL ignored_load_cycles got=%0d want=16", drv); end
        bus.load_start = 1'b1; bus.load_valid = 1'b1; bus.load_data = 8'hEE;
        @(negedge clk);
        bus.load_start = 1'b0; bus.load_valid = 1'b0;
        for (int j = 1; j <= HOLD_N; j++) begin
            if (j > 1) @(negedge clk);
            checks++;
            if (cpu_n_reset !== (j == HOLD_N)) begin errors++; $display("FAIL ignored_release edge=last+%0d got=%b want=%b", j, cpu_n_reset, j == HOLD_N); end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL ignored_restart busy=%b want=0", busy); end
        checks++;
        if (load_sum !== model_sum(prog)) begin errors++; $display("FAIL ignored_sum got=%h want=%h", load_sum, model_sum(prog)); end
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a); #1;
            checks++;
            if (bus.data !== prog[a]) begin errors++; $display("FAIL ignored_mem addr=%0d got=%h want=%h", a, bus.data, prog[a]); end
        end
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] prog [16];
        int rdy, drv, last; bit to;
        for (int i = 0; i < 16; i++) prog[i] = 8'($urandom_range(1, 255));
        wait_idle(to);
        run_load(prog, 0, 7, -1, rdy, drv, last, to);
        rd_addr = 4'd3; #1;
        checks++;
        if (bus.data !== prog[3]) begin errors++; $display("FAIL midrst_partial addr=3 got=%h want=%h", bus.data, prog[3]); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (load_sum !== 8'h00) begin errors++; $display("FAIL midrst_sum got=%h want=00", load_sum); end
        checks++;
        if (cpu_n_reset !== 1'b0) begin errors++; $display("FAIL midrst_cpu_n_reset got=%b want=0", cpu_n_reset); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy got=%b want=1", busy); end
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a); #1;
            checks++;
            if (bus.data !== NOP_WORD) begin errors++; $display("FAIL midrst_mem addr=%0d got=%h want=%h", a, bus.data, NOP_WORD); end
        end
    endtask

    task automatic test_end_to_end();
        logic [7:0] prog [16];
        int rdy, drv, last, n; bit to;
        prog[0] = mk_instr(OP_OUT_I, 4'h5);
        for (int i = 1; i < 16; i++) prog[i] = mk_instr(OP_JMP, 4'h0);
        wait_idle(to);
        cpu_mode = 1'b1;
        run_load(prog, 0, 16, -1, rdy, drv, last, to);
        n = 0;
        while (cpu_n_reset !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20) begin errors++; $display("FAIL e2e_release cpu_n_reset=%b want=1", cpu_n_reset); end
        checks++;
        if (led !== 4'b0000) begin errors++; $display("FAIL e2e_led_held got=%b want=0000", led); end
        repeat (2) @(negedge clk);
        checks++;
        if (led !== 4'b0101) begin errors++; $display("FAIL e2e_led got=%b want=0101", led); end
        cpu_mode = 1'b0;
    endtask

    initial begin
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = 8'h00;
        test_reset();
        test_full_load();
        test_gapped_valid();
        test_ignored_starts();
        test_random_loads();
        test_reset_mid_load();
        test_end_to_end();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
